// File: rtl/fifo_pkg.sv
// Shared definitions for the flagged FIFO: request encoding and count sizing.
package fifo_pkg;

  // Encodings of the {Write, Read} request pair.
  localparam logic [1:0] OP_IDLE  = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_RDWR  = 2'b11;

  // The occupancy count needs one bit more than the pointers so that DEPTH fits.
  function automatic int count_width(input int addr_bits);
    return addr_bits + 1;
  endfunction

endpackage

// File: rtl/fifo_regfile.sv
// Register-array storage: synchronous write port, asynchronous (show-ahead) read port.
module fifo_regfile #(
  parameter int WIDTH     = 8,
  parameter int ADDR_BITS = 4
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] waddr_i,
  input  logic [WIDTH-1:0]     wdata_i,
  input  logic [ADDR_BITS-1:0] raddr_i,
  output logic [WIDTH-1:0]     rdata_o
);

  logic [WIDTH-1:0] mem_q [2**ADDR_BITS];

  // Contents are deliberately not reset; the control logic tracks validity.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_flagged.sv
// Synchronous FIFO with occupancy count, registered threshold flags and sticky error flags.
module fifo_flagged
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ADDR_BITS = 4,
  parameter int AF_LEVEL  = 2**ADDR_BITS - 1,
  parameter int AE_LEVEL  = 1
) (
  input  logic                              Clock,
  input  logic                              ResetN,
  input  logic                              Write,
  input  logic [WIDTH-1:0]                  WriteData,
  input  logic                              Read,
  output logic [WIDTH-1:0]                  ReadData,
  output logic                              Empty,
  output logic                              Full,
  output logic                              AlmostEmpty,
  output logic                              AlmostFull,
  output logic [count_width(ADDR_BITS)-1:0] Count,
  output logic                              Overflow,
  output logic                              Underflow,
  input  logic                              ClearErr
);

  localparam int CW    = count_width(ADDR_BITS);
  localparam int DEPTH = 2**ADDR_BITS;

  // Handshake: Write and Read are single-cycle requests sampled on every rising
  // edge. A push is accepted when the FIFO is not full or a pop in the same cycle
  // frees a slot; a pop is accepted when the FIFO is not empty. Rejected requests
  // change no pointer, count or storage and only raise the matching sticky flag.

  logic [ADDR_BITS-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 empty_q, empty_d, full_q, full_d;
  logic                 aempty_q, aempty_d, afull_q, afull_d;
  logic                 ovf_q, ovf_d, udf_q, udf_d;
  logic                 push_en, pop_en, ovf_set, udf_set;
  logic [1:0]           op;

  always_comb begin
    op      = {Write, Read};
    push_en = Write & (~full_q | Read);
    pop_en  = Read & ~empty_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_set = 1'b0;
    udf_set = 1'b0;

    if (push_en) wptr_d = wptr_q + ADDR_BITS'(1);
    if (pop_en)  rptr_d = rptr_q + ADDR_BITS'(1);

    case ({push_en, pop_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    case (op)
      OP_IDLE:  ;
      OP_WRITE: ovf_set = full_q;
      OP_READ:  udf_set = empty_q;
      OP_RDWR:  udf_set = empty_q;
      default:  ;
    endcase

    // A set condition takes priority over a simultaneous clear.
    ovf_d = ovf_set | (ovf_q & ~ClearErr);
    udf_d = udf_set | (udf_q & ~ClearErr);

    // Flags are derived from the next count so they line up with Count each cycle.
    empty_d  = (count_d == '0);
    full_d   = (count_d == CW'(DEPTH));
    aempty_d = (count_d <= CW'(AE_LEVEL));
    afull_d  = (count_d >= CW'(AF_LEVEL));
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      aempty_q <= 1'b1;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      aempty_q <= aempty_d;
      afull_q  <= afull_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fifo_regfile #(
    .WIDTH     (WIDTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_regfile (
    .clk_i   (Clock),
    .we_i    (push_en),
    .waddr_i (wptr_q),
    .wdata_i (WriteData),
    .raddr_i (rptr_q),
    .rdata_o (ReadData)
  );

  assign Empty       = empty_q;
  assign Full        = full_q;
  assign AlmostEmpty = aempty_q;
  assign AlmostFull  = afull_q;
  assign Count       = count_q;
  assign Overflow    = ovf_q;
  assign Underflow   = udf_q;

endmodule
